// File: rtl/mem_pkg.sv
// Shared types and width helpers for the L1 line refill engine.
// Pure declarations: no latency, no flow control.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        GAP,
        DONE
    } refill_state_t;

    // Widths for the default 8-word line; parametrised users call the functions below.
    localparam int DEF_WORDS_PER_LINE = 8;
    localparam int IDX_BITS           = $clog2(DEF_WORDS_PER_LINE);
    localparam int OFFSET_BITS        = IDX_BITS + 2;

    function automatic int idx_bits(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int offset_bits(input int words_per_line);
        return $clog2(words_per_line) + 2;
    endfunction

    function automatic int port_bits(input int num_ports);
        return (num_ports > 1) ? $clog2(num_ports) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first set request at or above ptr, wrapping upward.
// Combinational, zero latency; a port with no request is simply skipped.
module rr_arbiter
    import mem_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = port_bits(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx,
    output logic          gnt_vld
);

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!gnt_vld && req[(int'(ptr) + k) % N]) begin
                gnt_vld                     = 1'b1;
                gnt_idx                     = PW'((int'(ptr) + k) % N);
                gnt[(int'(ptr) + k) % N]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/l1_refill_engine.sv
// Streams whole cache lines between NUM_PORTS L1s and single-ported main memory.
// Grant one cycle after request; each word waits for mm_valid, then one idle GAP cycle.
module l1_refill_engine
    import mem_pkg::*;
#(
    parameter int NUM_PORTS      = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int WORD_SIZE      = 32,
    parameter int WORDS_PER_LINE = 8
) (
    input  logic                            MEM_CLK,
    input  logic                            RST,
    input  logic [NUM_PORTS-1:0]            req_valid,
    input  logic [NUM_PORTS-1:0]            req_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_PORTS-1:0]            req_ready,
    input  logic [NUM_PORTS*WORD_SIZE-1:0]  wb_data,
    output logic [NUM_PORTS-1:0]            wb_rd,
    output logic [NUM_PORTS-1:0]            fill_valid,
    output logic [WORD_SIZE-1:0]            fill_data,
    output logic [$clog2(WORDS_PER_LINE)-1:0] fill_idx,
    output logic [NUM_PORTS-1:0]            done,
    output logic                            mm_re,
    output logic                            mm_we,
    output logic [ADDR_WIDTH-3:0]           mm_addr,
    output logic [WORD_SIZE-1:0]            mm_din,
    input  logic [WORD_SIZE-1:0]            mm_dout,
    input  logic                            mm_valid
);

    localparam int PW     = port_bits(NUM_PORTS);
    localparam int IW     = idx_bits(WORDS_PER_LINE);
    localparam int OW     = offset_bits(WORDS_PER_LINE);
    localparam int MW     = ADDR_WIDTH - 2;
    localparam int LINE_W = ADDR_WIDTH - OW;

    refill_state_t         state_q, state_d;
    logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]         grant_q, grant_d;
    logic [IW-1:0]         cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic [MW-1:0]         base_q, base_d;
    logic [NUM_PORTS-1:0]  req_ready_q, req_ready_d;

    logic [NUM_PORTS-1:0]  arb_gnt;
    logic [PW-1:0]         arb_idx;
    logic                  arb_vld;
    logic [LINE_W-1:0]     sel_line;
    logic [WORD_SIZE-1:0]  wb_word;

    rr_arbiter #(
        .N  (NUM_PORTS),
        .PW (PW)
    ) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    // Only the line-number bits of the winner's address are kept; offset is implied zero.
    assign sel_line  = req_addr[arb_idx*ADDR_WIDTH + OW +: LINE_W];
    assign wb_word   = wb_data[grant_q*WORD_SIZE +: WORD_SIZE];
    assign req_ready = req_ready_q;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        base_d      = base_q;
        req_ready_d = '0;
        fill_valid  = '0;
        fill_data   = '0;
        fill_idx    = '0;
        wb_rd       = '0;
        done        = '0;
        mm_re       = 1'b0;
        mm_we       = 1'b0;
        mm_addr     = '0;
        mm_din      = '0;

        unique case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    req_ready_d = arb_gnt;
                    grant_d     = arb_idx;
                    wr_d        = req_write[arb_idx];
                    base_d      = {sel_line, IW'(0)};
                    cnt_d       = '0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                mm_re   = !wr_q;
                mm_we   = wr_q;
                mm_addr = base_q + MW'(cnt_q);
                mm_din  = wb_word;
                if (mm_valid) begin
                    if (wr_q) begin
                        wb_rd[grant_q] = 1'b1;
                    end else begin
                        fill_valid[grant_q] = 1'b1;
                        fill_data           = mm_dout;
                        fill_idx            = cnt_q;
                    end
                    // cnt wraps to zero after the last word, ready for the next line.
                    cnt_d   = cnt_q + IW'(1);
                    state_d = (cnt_q == IW'(WORDS_PER_LINE - 1)) ? DONE : GAP;
                end
            end
            GAP: begin
                state_d = ISSUE;
            end
            DONE: begin
                done[grant_q] = 1'b1;
                rr_ptr_d      = (grant_q == PW'(NUM_PORTS - 1)) ? '0 : grant_q + PW'(1);
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge MEM_CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            base_q      <= '0;
            req_ready_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            base_q      <= base_d;
            req_ready_q <= req_ready_d;
        end
    end

endmodule

// File: tb/tb_l1_refill_engine.sv
// Directed bench for l1_refill_engine: a 2-port/8-word instance and a 4-port/4-word instance,
// each backed by a fixed-delay main-memory model.
`timescale 1ns/1ps
module tb_l1_refill_engine;

    logic MEM_CLK = 1'b0;
    always #5 MEM_CLK = ~MEM_CLK;
    logic RST;

    int n_total = 0;
    int n_pass  = 0;
    int mem_delay = 3;

    // ---------------- instance A: 2 ports, 8 words ----------------
    logic [1:0]  a_req_valid, a_req_write, a_req_ready, a_wb_rd, a_fill_valid, a_done;
    logic [63:0] a_req_addr, a_wb_data;
    logic [31:0] a_fill_data, a_mm_din, a_mm_dout;
    logic [2:0]  a_fill_idx;
    logic        a_mm_re, a_mm_we, a_mm_valid;
    logic [29:0] a_mm_addr;
    int          a_mcnt = 0;
    int          a_wbc0 = 0;
    int          a_wbc1 = 0;

    l1_refill_engine #(
        .NUM_PORTS(2), .ADDR_WIDTH(32), .WORD_SIZE(32), .WORDS_PER_LINE(8)
    ) dut_a (
        .MEM_CLK(MEM_CLK), .RST(RST),
        .req_valid(a_req_valid), .req_write(a_req_write), .req_addr(a_req_addr),
        .req_ready(a_req_ready), .wb_data(a_wb_data), .wb_rd(a_wb_rd),
        .fill_valid(a_fill_valid), .fill_data(a_fill_data), .fill_idx(a_fill_idx),
        .done(a_done), .mm_re(a_mm_re), .mm_we(a_mm_we), .mm_addr(a_mm_addr),
        .mm_din(a_mm_din), .mm_dout(a_mm_dout), .mm_valid(a_mm_valid)
    );

    // Memory completes a word in the mem_delay-th consecutive cycle of an active request.
    assign a_mm_valid = (a_mm_re || a_mm_we) && (a_mcnt == mem_delay - 1);
    assign a_mm_dout  = {2'b10, a_mm_addr} ^ 32'h5A5A_0000;
    assign a_wb_data  = {32'hB100_0000 + a_wbc1, 32'hB000_0000 + a_wbc0};
    always @(posedge MEM_CLK) begin
        if (a_mm_re || a_mm_we) a_mcnt <= a_mm_valid ? 0 : a_mcnt + 1;
        else                    a_mcnt <= 0;
        if (a_wb_rd[0]) a_wbc0 <= a_wbc0 + 1;
        if (a_wb_rd[1]) a_wbc1 <= a_wbc1 + 1;
    end

    // ---------------- instance B: 4 ports, 4 words ----------------
    logic [3:0]   b_req_valid, b_req_write, b_req_ready, b_wb_rd, b_fill_valid, b_done;
    logic [127:0] b_req_addr, b_wb_data;
    logic [31:0]  b_fill_data, b_mm_din, b_mm_dout;
    logic [1:0]   b_fill_idx;
    logic         b_mm_re, b_mm_we, b_mm_valid;
    logic [29:0]  b_mm_addr;
    int           b_mcnt = 0;

    l1_refill_engine #(
        .NUM_PORTS(4), .ADDR_WIDTH(32), .WORD_SIZE(32), .WORDS_PER_LINE(4)
    ) dut_b (
        .MEM_CLK(MEM_CLK), .RST(RST),
        .req_valid(b_req_valid), .req_write(b_req_write), .req_addr(b_req_addr),
        .req_ready(b_req_ready), .wb_data(b_wb_data), .wb_rd(b_wb_rd),
        .fill_valid(b_fill_valid), .fill_data(b_fill_data), .fill_idx(b_fill_idx),
        .done(b_done), .mm_re(b_mm_re), .mm_we(b_mm_we), .mm_addr(b_mm_addr),
        .mm_din(b_mm_din), .mm_dout(b_mm_dout), .mm_valid(b_mm_valid)
    );

    assign b_mm_valid = (b_mm_re || b_mm_we) && (b_mcnt == mem_delay - 1);
    assign b_mm_dout  = {2'b10, b_mm_addr} ^ 32'h5A5A_0000;
    assign b_wb_data  = {32'hB300_0000, 32'hB200_0000, 32'hB100_0000, 32'hB000_0000};
    always @(posedge MEM_CLK) begin
        if (b_mm_re || b_mm_we) b_mcnt <= b_mm_valid ? 0 : b_mcnt + 1;
        else                    b_mcnt <= 0;
    end

    // ---------------- common view of the selected instance ----------------
    bit          sel = 1'b0;
    logic [3:0]  v_ready, v_fv, v_wbrd, v_done;
    logic        v_re, v_we;
    logic [29:0] v_addr;
    logic [31:0] v_fdata, v_din;
    logic [2:0]  v_idx;

    always_comb begin
        if (sel) begin
            v_ready = b_req_ready; v_fv = b_fill_valid; v_wbrd = b_wb_rd; v_done = b_done;
            v_re = b_mm_re; v_we = b_mm_we; v_addr = b_mm_addr;
            v_fdata = b_fill_data; v_din = b_mm_din; v_idx = {1'b0, b_fill_idx};
        end else begin
            v_ready = {2'b00, a_req_ready}; v_fv = {2'b00, a_fill_valid};
            v_wbrd = {2'b00, a_wb_rd}; v_done = {2'b00, a_done};
            v_re = a_mm_re; v_we = a_mm_we; v_addr = a_mm_addr;
            v_fdata = a_fill_data; v_din = a_mm_din; v_idx = a_fill_idx;
        end
    end

    // Observations of one transfer, filled by observe_xfer (records only, compares nothing).
    int          obs_wait, obs_words, obs_done_off, obs_gap_bad, obs_tail_idle;
    int          obs_re_cyc, obs_we_cyc, obs_both, obs_multi;
    logic [3:0]  obs_ready, obs_done;
    logic        obs_re0, obs_we0;
    bit          obs_timeout;
    logic [29:0] obs_addr[8];
    logic [31:0] obs_data[8];
    logic [2:0]  obs_idx[8];
    logic [3:0]  obs_strobe[8];

    task automatic observe_xfer();
        int idle_run;
        obs_timeout = 1'b0; obs_words = 0; obs_done_off = -1; obs_gap_bad = 0;
        obs_tail_idle = -1; obs_re_cyc = 0; obs_we_cyc = 0; obs_both = 0; obs_multi = 0;
        obs_ready = '0; obs_done = '0; obs_re0 = 1'b0; obs_we0 = 1'b0; obs_wait = 0;
        for (int k = 0; k < 8; k++) begin
            obs_addr[k] = 'x; obs_data[k] = 'x; obs_idx[k] = 'x; obs_strobe[k] = 'x;
        end
        do begin
            @(negedge MEM_CLK);
            obs_wait++;
        end while (v_ready == 4'b0 && obs_wait < 60);
        if (v_ready == 4'b0) begin
            obs_timeout = 1'b1;
            return;
        end
        obs_ready = v_ready; obs_re0 = v_re; obs_we0 = v_we;
        idle_run = 0;
        for (int off = 0; off < 200; off++) begin
            if (off > 0) @(negedge MEM_CLK);
            if (v_re) obs_re_cyc++;
            if (v_we) obs_we_cyc++;
            if (v_re && v_we) obs_both++;
            if ($countones(v_ready) > 1 || $countones(v_fv) > 1 ||
                $countones(v_wbrd) > 1 || $countones(v_done) > 1) obs_multi++;
            if ((v_fv | v_wbrd) != 4'b0) begin
                if (obs_words < 8) begin
                    obs_addr[obs_words]   = v_addr;
                    obs_data[obs_words]   = (v_fv != 4'b0) ? v_fdata : v_din;
                    obs_idx[obs_words]    = v_idx;
                    obs_strobe[obs_words] = v_fv | v_wbrd;
                end
                if (obs_words > 0 && idle_run != 1) obs_gap_bad++;
                obs_words++;
                idle_run = 0;
            end else if (!v_re && !v_we) begin
                idle_run++;
            end
            if (v_done != 4'b0) begin
                obs_done = v_done; obs_done_off = off; obs_tail_idle = idle_run;
                if (sel) b_req_valid = b_req_valid & ~v_done;
                else     a_req_valid = a_req_valid & ~v_done[1:0];
                return;
            end
        end
        obs_timeout = 1'b1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        a_req_valid = '0; a_req_write = '0; a_req_addr = '0;
        b_req_valid = '0; b_req_write = '0; b_req_addr = '0;
        repeat (2) @(negedge MEM_CLK);
        n_total++;
        if ({a_req_ready, a_wb_rd, a_fill_valid, a_done, a_mm_re, a_mm_we} !== 10'b0)
            $display("FAIL reset_a_strobes: got %b expected 0",
                     {a_req_ready, a_wb_rd, a_fill_valid, a_done, a_mm_re, a_mm_we});
        else n_pass++;
        n_total++;
        if ({a_fill_data, a_fill_idx, a_mm_addr, a_mm_din} !== 97'b0)
            $display("FAIL reset_a_data: got %h expected 0",
                     {a_fill_data, a_fill_idx, a_mm_addr, a_mm_din});
        else n_pass++;
        n_total++;
        if ({b_req_ready, b_wb_rd, b_fill_valid, b_done, b_mm_re, b_mm_we, b_mm_addr, b_mm_din} !== 80'b0)
            $display("FAIL reset_b_outputs: got %h expected 0",
                     {b_req_ready, b_wb_rd, b_fill_valid, b_done, b_mm_re, b_mm_we, b_mm_addr, b_mm_din});
        else n_pass++;
        RST = 1'b0;
    endtask

    task automatic test_single_fill();
        logic [29:0] ea;
        sel = 1'b0; mem_delay = 3;
        a_req_addr[31:0] = 32'h0000_6024; a_req_write = 2'b00; a_req_valid = 2'b01;
        observe_xfer();
        n_total++;
        if (obs_timeout) $display("FAIL fill_timeout: transfer did not complete"); else n_pass++;
        n_total++;
        if (obs_ready !== 4'b0001 || obs_re0 !== 1'b1 || obs_we0 !== 1'b0)
            $display("FAIL fill_grant: ready=%b re=%b we=%b expected 0001 1 0", obs_ready, obs_re0, obs_we0);
        else n_pass++;
        n_total++;
        if (obs_words !== 8) $display("FAIL fill_words: got %0d expected 8", obs_words); else n_pass++;
        for (int k = 0; k < 8; k++) begin
            ea = 30'h1808 + 30'(k);
            n_total++;
            if (obs_addr[k] !== ea || obs_idx[k] !== 3'(k) || obs_strobe[k] !== 4'b0001 ||
                obs_data[k] !== ({2'b10, ea} ^ 32'h5A5A_0000))
                $display("FAIL fill_word%0d: addr=%h idx=%0d strobe=%b data=%h expected addr=%h idx=%0d strobe=0001 data=%h",
                         k, obs_addr[k], obs_idx[k], obs_strobe[k], obs_data[k], ea, k, {2'b10, ea} ^ 32'h5A5A_0000);
            else n_pass++;
        end
        n_total++;
        if (obs_gap_bad !== 0 || obs_tail_idle !== 1)
            $display("FAIL fill_gap: bad_gaps=%0d tail_idle=%0d expected 0 1", obs_gap_bad, obs_tail_idle);
        else n_pass++;
        // done is the (8*3+7+1)th cycle counting the req_ready cycle as the first.
        n_total++;
        if (obs_done !== 4'b0001 || obs_done_off !== 8*3+7)
            $display("FAIL fill_done: done=%b offset=%0d expected 0001 %0d", obs_done, obs_done_off, 8*3+7);
        else n_pass++;
        n_total++;
        if (obs_re_cyc !== 24 || obs_we_cyc !== 0 || obs_both !== 0 || obs_multi !== 0)
            $display("FAIL fill_mm_ctrl: re=%0d we=%0d both=%0d multi=%0d expected 24 0 0 0",
                     obs_re_cyc, obs_we_cyc, obs_both, obs_multi);
        else n_pass++;
    endtask

    task automatic test_write_back();
        sel = 1'b0; mem_delay = 2;
        a_req_addr[63:32] = 32'h0000_7000; a_req_write = 2'b10; a_req_valid = 2'b10;
        observe_xfer();
        n_total++;
        if (obs_timeout) $display("FAIL wb_timeout: transfer did not complete"); else n_pass++;
        n_total++;
        if (obs_ready !== 4'b0010 || obs_re0 !== 1'b0 || obs_we0 !== 1'b1)
            $display("FAIL wb_grant: ready=%b re=%b we=%b expected 0010 0 1", obs_ready, obs_re0, obs_we0);
        else n_pass++;
        for (int k = 0; k < 8; k++) begin
            n_total++;
            if (obs_addr[k] !== 30'h1C00 + 30'(k) || obs_strobe[k] !== 4'b0010 ||
                obs_data[k] !== 32'hB100_0000 + 32'(k))
                $display("FAIL wb_word%0d: addr=%h strobe=%b data=%h expected addr=%h strobe=0010 data=%h",
                         k, obs_addr[k], obs_strobe[k], obs_data[k], 30'h1C00 + 30'(k), 32'hB100_0000 + 32'(k));
            else n_pass++;
        end
        n_total++;
        if (obs_words !== 8 || obs_re_cyc !== 0 || obs_we_cyc !== 16 || obs_both !== 0)
            $display("FAIL wb_mm_ctrl: words=%0d re=%0d we=%0d both=%0d expected 8 0 16 0",
                     obs_words, obs_re_cyc, obs_we_cyc, obs_both);
        else n_pass++;
        n_total++;
        if (obs_done !== 4'b0010 || obs_done_off !== 8*2+7 || obs_gap_bad !== 0 || obs_tail_idle !== 1)
            $display("FAIL wb_done: done=%b offset=%0d gaps=%0d tail=%0d expected 0010 %0d 0 1",
                     obs_done, obs_done_off, obs_gap_bad, obs_tail_idle, 8*2+7);
        else n_pass++;
    endtask

    task automatic test_contention();
        sel = 1'b0; mem_delay = 2;
        a_req_addr = {32'h0000_7000, 32'h0000_6024}; a_req_write = 2'b00; a_req_valid = 2'b11;
        observe_xfer();
        n_total++;
        if (obs_timeout || obs_ready !== 4'b0001 || obs_done !== 4'b0001 || obs_addr[0] !== 30'h1808)
            $display("FAIL cont_first: ready=%b done=%b addr0=%h expected 0001 0001 1808",
                     obs_ready, obs_done, obs_addr[0]);
        else n_pass++;
        a_req_valid[0] = 1'b1;
        observe_xfer();
        n_total++;
        if (obs_timeout || obs_ready !== 4'b0010 || obs_done !== 4'b0010 || obs_addr[0] !== 30'h1C00)
            $display("FAIL cont_second: ready=%b done=%b addr0=%h expected 0010 0010 1c00",
                     obs_ready, obs_done, obs_addr[0]);
        else n_pass++;
        n_total++;
        if (obs_wait !== 2) $display("FAIL cont_regrant_delay: got %0d expected 2", obs_wait); else n_pass++;
        observe_xfer();
        n_total++;
        if (obs_timeout || obs_ready !== 4'b0001 || obs_done !== 4'b0001 || obs_wait !== 2)
            $display("FAIL cont_third: ready=%b done=%b wait=%0d expected 0001 0001 2",
                     obs_ready, obs_done, obs_wait);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int  cyc;
        bit  seen;
        logic [1:0] done_seen;
        sel = 1'b0; mem_delay = 3;
        a_req_addr[31:0] = 32'h0000_6024; a_req_write = 2'b00; a_req_valid = 2'b01;
        seen = 1'b0; cyc = 0;
        while (!seen && cyc < 80) begin
            @(negedge MEM_CLK);
            cyc++;
            if (a_fill_valid[0] && a_fill_idx == 3'd3) seen = 1'b1;
        end
        n_total++;
        if (!seen) $display("FAIL rstmid_word3: word 3 never arrived"); else n_pass++;
        #2 RST = 1'b1;
        #1;
        n_total++;
        if ({a_req_ready, a_wb_rd, a_fill_valid, a_done, a_mm_re, a_mm_we, a_fill_data, a_fill_idx, a_mm_addr, a_mm_din} !== 107'b0)
            $display("FAIL rstmid_async_outputs: got %h expected 0",
                     {a_req_ready, a_wb_rd, a_fill_valid, a_done, a_mm_re, a_mm_we, a_fill_data, a_fill_idx, a_mm_addr, a_mm_din});
        else n_pass++;
        done_seen = '0;
        repeat (3) begin
            @(negedge MEM_CLK);
            done_seen = done_seen | a_done;
        end
        RST = 1'b0;
        repeat (2) begin
            @(negedge MEM_CLK);
            done_seen = done_seen | a_done;
        end
        n_total++;
        if (done_seen !== 2'b00) $display("FAIL rstmid_no_done: got %b expected 00", done_seen); else n_pass++;
        observe_xfer();
        n_total++;
        if (obs_timeout || obs_ready !== 4'b0001 || obs_idx[0] !== 3'd0 || obs_addr[0] !== 30'h1808 ||
            obs_words !== 8 || obs_done !== 4'b0001)
            $display("FAIL rstmid_restart: ready=%b idx0=%0d addr0=%h words=%0d done=%b expected 0001 0 1808 8 0001",
                     obs_ready, obs_idx[0], obs_addr[0], obs_words, obs_done);
        else n_pass++;
    endtask

    task automatic test_sweep();
        logic [29:0] ea;
        sel = 1'b1; mem_delay = 1;
        b_req_write = 4'b0000;
        for (int p = 0; p < 4; p++) b_req_addr[p*32 +: 32] = 32'h0000_2000 + 32'(p) * 32'h100 + 32'h7;
        b_req_valid = 4'b1111;
        for (int p = 0; p < 4; p++) begin
            observe_xfer();
            n_total++;
            if (obs_timeout || obs_ready !== 4'(1 << p) || obs_done !== 4'(1 << p) ||
                obs_words !== 4 || obs_done_off !== 4*1+3 || obs_gap_bad !== 0)
                $display("FAIL sweep_port%0d: ready=%b done=%b words=%0d off=%0d gaps=%0d expected %b %b 4 7 0",
                         p, obs_ready, obs_done, obs_words, obs_done_off, obs_gap_bad, 4'(1 << p), 4'(1 << p));
            else n_pass++;
            for (int k = 0; k < 4; k++) begin
                ea = 30'h800 + 30'(p) * 30'h40 + 30'(k);
                n_total++;
                if (obs_idx[k] !== 3'(k) || obs_addr[k] !== ea || obs_data[k] !== ({2'b10, ea} ^ 32'h5A5A_0000))
                    $display("FAIL sweep_p%0d_w%0d: idx=%0d addr=%h data=%h expected idx=%0d addr=%h",
                             p, k, obs_idx[k], obs_addr[k], obs_data[k], k, ea);
                else n_pass++;
            end
        end
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_fill();
        test_write_back();
        test_contention();
        test_reset_mid();
        test_sweep();
        repeat (2) @(negedge MEM_CLK);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
